// File: rtl/mac_acc_pkg.sv
// Shared types and constants for the mac_acc8u accumulation stage.
//   state_e   : run-control FSM states (IDLE, ACC, DONE)
//   PROD_W    : width of an incoming product from the 8x8 multiplier
//   ACC_W_DEF : default accumulator / result width
//   CNT_W_DEF : default width of the run-length field
package mac_acc_pkg;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mac_acc8u_if.sv
// Handshake bundle between a product source / result sink and mac_acc8u.
//   master : source/sink side (drives start, len, in_valid, in_product, out_ready)
//   slave  : accumulator side (drives in_ready, out_valid, out_sum, out_ovf, busy)
interface mac_acc8u_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  import mac_acc_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic              busy;

  modport master (
    output start, len, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/mac_acc_add.sv
// Combinational accumulate step: i_acc + zero-extended i_prod.
//   i_acc   : current accumulator value (ACC_W)
//   i_prod  : unsigned product (PROD_W)
//   o_sum   : next accumulator value (ACC_W)
//   o_carry : carry out of ACC_W bits
// Build option ACC_SAT_EN: on carry the sum clamps to all ones instead of
// wrapping. Once clamped, any further add also carries (or adds zero), so the
// value stays pinned for the rest of the run without extra state.
module mac_acc_add
  import mac_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);
  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + {{(ACC_W+1-PROD_W){1'b0}}, i_prod};
  assign o_carry = w_full[ACC_W];

`ifdef ACC_SAT_EN
  assign o_sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif
endmodule

// File: rtl/mac_acc8u.sv
// Accumulation stage behind the 8x8 unsigned multiplier. Sums `len` products
// received over the input handshake and returns the sum over the output
// handshake.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, priority over everything
//   bus  : mac_acc8u_if.slave (start/len, in_* stream, out_* result, busy)
// Build option ACC_SAT_EN: saturate the accumulator instead of wrapping
// (implemented in mac_acc_add).
module mac_acc8u
  import mac_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mac_acc8u_if.slave  bus
);
  state_e           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_rem;
  logic             r_run_ovf;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  mac_acc_add #(.ACC_W(ACC_W)) u_add (
    .i_acc   (r_acc),
    .i_prod  (bus.in_product),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Handshake outputs are registered alongside the state so they change
  // exactly on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_run_ovf   <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.len != '0) begin
              r_acc      <= '0;
              r_run_ovf  <= 1'b0;
              r_rem      <= bus.len;
              r_in_ready <= 1'b1;
              r_state    <= ACC;
            end else begin
              // Empty run: report a zero result straight away.
              r_out_sum   <= '0;
              r_out_ovf   <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            r_acc     <= w_sum;
            r_run_ovf <= r_run_ovf | w_carry;
            r_rem     <= r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              r_out_sum   <= w_sum;
              r_out_ovf   <= r_run_ovf | w_carry;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mac_acc8u.sv
// Directed bench for mac_acc8u: a 24-bit instance for the main scenarios and a
// 16-bit instance for the carry/saturation case. Inputs change 1 time unit
// after the rising edge; outputs are read at that same point, i.e. after the
// registers have settled from the edge.
module tb_mac_acc8u;
  import mac_acc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mac_acc8u_if #(.ACC_W(24), .CNT_W(8)) b24 ();
  mac_acc8u_if #(.ACC_W(16), .CNT_W(8)) b16 ();

  mac_acc8u #(.ACC_W(24), .CNT_W(8)) u24 (.clk(clk), .rst(rst), .bus(b24.slave));
  mac_acc8u #(.ACC_W(16), .CNT_W(8)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

`ifdef ACC_SAT_EN
  localparam logic [15:0] OVF_SUM = 16'hFFFF;
`else
  localparam logic [15:0] OVF_SUM = 16'h0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (b24.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", b24.in_ready); end
    checks++; if (b24.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", b24.out_valid); end
    checks++; if (b24.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", b24.busy); end
    checks++; if (b24.out_sum !== 24'd0 || b24.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_sum got %0d/%b exp 0/0", b24.out_sum, b24.out_ovf); end
  endtask

  task automatic test_back_to_back();
    b24.out_ready = 1'b1;
    b24.start = 1'b1; b24.len = 8'd3;
    step();
    b24.start = 1'b0;
    checks++; if (b24.in_ready !== 1'b1 || b24.busy !== 1'b1) begin errors++; $display("FAIL b2b_enter_acc got rdy=%b busy=%b exp 1/1", b24.in_ready, b24.busy); end
    b24.in_valid = 1'b1;
    b24.in_product = 16'd100; step();
    b24.in_product = 16'd200; step();
    b24.in_product = 16'd300; step();
    b24.in_valid = 1'b0;
    checks++; if (b24.out_valid !== 1'b1 || b24.out_sum !== 24'd600 || b24.out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_result got v=%b sum=%0d ovf=%b exp 1/600/0", b24.out_valid, b24.out_sum, b24.out_ovf); end
    checks++; if (b24.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_done got %b exp 0", b24.in_ready); end
    step();
    checks++; if (b24.out_valid !== 1'b0 || b24.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got v=%b busy=%b exp 0/0", b24.out_valid, b24.busy); end
  endtask

  task automatic test_len_zero();
    b24.out_ready = 1'b0;
    b24.start = 1'b1; b24.len = 8'd0;
    step();
    b24.start = 1'b0;
    checks++; if (b24.out_valid !== 1'b1 || b24.out_sum !== 24'd0 || b24.out_ovf !== 1'b0) begin errors++; $display("FAIL len0_result got v=%b sum=%0d ovf=%b exp 1/0/0", b24.out_valid, b24.out_sum, b24.out_ovf); end
    checks++; if (b24.in_ready !== 1'b0) begin errors++; $display("FAIL len0_ready got %b exp 0", b24.in_ready); end
    b24.out_ready = 1'b1;
    step();
    checks++; if (b24.out_valid !== 1'b0 || b24.in_ready !== 1'b0 || b24.busy !== 1'b0) begin errors++; $display("FAIL len0_idle got v=%b rdy=%b busy=%b exp 0/0/0", b24.out_valid, b24.in_ready, b24.busy); end
  endtask

  task automatic test_stall();
    b24.start = 1'b1; b24.len = 8'd2;
    step();
    b24.start = 1'b0;
    b24.in_valid = 1'b1; b24.in_product = 16'd65025;
    step();
    b24.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (b24.out_valid !== 1'b0 || b24.in_ready !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got v=%b rdy=%b exp 0/1", i, b24.out_valid, b24.in_ready); end
    end
    b24.in_valid = 1'b1;
    step();
    b24.in_valid = 1'b0;
    checks++; if (b24.out_valid !== 1'b1 || b24.out_sum !== 24'd130050 || b24.out_ovf !== 1'b0) begin errors++; $display("FAIL stall_result got v=%b sum=%0d ovf=%b exp 1/130050/0", b24.out_valid, b24.out_sum, b24.out_ovf); end
    step();
  endtask

  task automatic test_overflow();
    b16.out_ready = 1'b1;
    b16.start = 1'b1; b16.len = 8'd2;
    step();
    b16.start = 1'b0;
    b16.in_valid = 1'b1;
    b16.in_product = 16'd65535; step();
    b16.in_product = 16'd1;     step();
    b16.in_valid = 1'b0;
    checks++; if (b16.out_valid !== 1'b1 || b16.out_sum !== OVF_SUM || b16.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_result got v=%b sum=%h ovf=%b exp 1/%h/1", b16.out_valid, b16.out_sum, b16.out_ovf, OVF_SUM); end
    step();
    // The next run must start with a clean flag.
    b16.start = 1'b1; b16.len = 8'd1;
    step();
    b16.start = 1'b0;
    b16.in_valid = 1'b1; b16.in_product = 16'd5;
    step();
    b16.in_valid = 1'b0;
    checks++; if (b16.out_valid !== 1'b1 || b16.out_sum !== 16'd5 || b16.out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got v=%b sum=%0d ovf=%b exp 1/5/0", b16.out_valid, b16.out_sum, b16.out_ovf); end
    step();
  endtask

  task automatic test_hold();
    b24.out_ready = 1'b0;
    b24.start = 1'b1; b24.len = 8'd1;
    step();
    b24.start = 1'b0;
    b24.in_valid = 1'b1; b24.in_product = 16'd42;
    step();
    b24.in_valid = 1'b0;
    b24.len = 8'd5;
    for (int i = 0; i < 10; i++) begin
      b24.start = (i == 3);
      step();
      checks++; if (b24.out_valid !== 1'b1 || b24.out_sum !== 24'd42 || b24.busy !== 1'b1 || b24.in_ready !== 1'b0) begin errors++; $display("FAIL hold[%0d] got v=%b sum=%0d busy=%b rdy=%b exp 1/42/1/0", i, b24.out_valid, b24.out_sum, b24.busy, b24.in_ready); end
    end
    b24.start = 1'b0;
    b24.out_ready = 1'b1;
    step();
    checks++; if (b24.out_valid !== 1'b0 || b24.busy !== 1'b0) begin errors++; $display("FAIL hold_release got v=%b busy=%b exp 0/0", b24.out_valid, b24.busy); end
    step();
    checks++; if (b24.busy !== 1'b0 || b24.in_ready !== 1'b0) begin errors++; $display("FAIL hold_no_queue got busy=%b rdy=%b exp 0/0", b24.busy, b24.in_ready); end
  endtask

  task automatic test_reset_mid_run();
    b24.out_ready = 1'b0;
    b24.start = 1'b1; b24.len = 8'd4;
    step();
    b24.start = 1'b0;
    b24.in_valid = 1'b1; b24.in_product = 16'd10;
    step(); step();
    b24.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (b24.in_ready !== 1'b0 || b24.out_valid !== 1'b0 || b24.busy !== 1'b0 || b24.out_sum !== 24'd0 || b24.out_ovf !== 1'b0) begin errors++; $display("FAIL midrst_outputs got rdy=%b v=%b busy=%b sum=%0d ovf=%b exp all 0", b24.in_ready, b24.out_valid, b24.busy, b24.out_sum, b24.out_ovf); end
    b24.start = 1'b1; b24.len = 8'd1;
    step();
    b24.start = 1'b0;
    b24.in_valid = 1'b1; b24.in_product = 16'd7;
    step();
    b24.in_valid = 1'b0;
    checks++; if (b24.out_valid !== 1'b1 || b24.out_sum !== 24'd7 || b24.out_ovf !== 1'b0) begin errors++; $display("FAIL midrst_fresh got v=%b sum=%0d ovf=%b exp 1/7/0", b24.out_valid, b24.out_sum, b24.out_ovf); end
    b24.out_ready = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b24.start = 1'b0; b24.len = '0; b24.in_valid = 1'b0; b24.in_product = '0; b24.out_ready = 1'b0;
    b16.start = 1'b0; b16.len = '0; b16.in_valid = 1'b0; b16.in_product = '0; b16.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_len_zero();
    test_stall();
    test_overflow();
    test_hold();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
